// File: rtl/oran_tod_pkg.sv
// Shared ToD definitions: word layout, nanosecond limit and lock FSM states.
package oran_tod_pkg;

  localparam int unsigned TOD_W      = 96;
  localparam int unsigned SEC_LSB    = 48;
  localparam int unsigned SEC_W      = 48;
  localparam int unsigned NS_LSB     = 16;
  localparam int unsigned NS_W       = 32;
  localparam int unsigned FRAC_LSB   = 0;
  localparam int unsigned FRAC_W     = 16;

  localparam logic [NS_W-1:0] NS_PER_SEC = 32'd1_000_000_000;

  // ToD word as carried on the bus
  typedef struct packed {
    logic [SEC_W-1:0]  sec;
    logic [NS_W-1:0]   ns;
    logic [FRAC_W-1:0] frac;
  } tod_word_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } tod_state_e;

endpackage

// File: rtl/oran_tod_pps_mon.sv
// ToD stream monitor: checks ns range and seconds continuity, tracks lock,
// and emits a 1PPS pulse on each seconds rollover while locked.
// Optional macro ORAN_TOD_PPS_ERR_CNT_EN enables the saturating error counter;
// without it err_count is tied to zero.
module oran_tod_pps_mon
  import oran_tod_pkg::*;
#(
  parameter int unsigned PPS_WIDTH     = 100,
  parameter int unsigned LOCK_SAMPLES  = 8,
  parameter int unsigned VALID_TIMEOUT = 64
) (
  input  logic        clk_tod_clk,
  input  logic        rst_tod_n_reset_n,
  input  logic [95:0] tod_in_data,
  input  logic        tod_in_valid,
  output logic        pps_out,
  output logic [47:0] seconds_out,
  output logic        locked,
  output logic        err_ns_range,
  output logic        err_monotonic,
  output logic [15:0] err_count
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO_W  = 16;
  localparam int unsigned PW_W  = 16;

  tod_word_t             in_tod_c;
  logic                  unused_frac_c;

  logic                  s1_valid;
  logic [SEC_W-1:0]      s1_sec;
  logic [NS_W-1:0]       s1_ns;

  logic [TO_W-1:0]       to_cnt;
  logic                  timeout_c;

  tod_state_e            state;
  tod_state_e            state_next;
  logic [CNT_W-1:0]      good_cnt;
  logic [CNT_W-1:0]      good_cnt_next;
  logic [CNT_W:0]        cnt_inc_c;

  logic                  ns_bad_c;
  logic                  sec_same_c;
  logic                  sec_next_c;
  logic                  mono_bad_c;
  logic                  good_c;
  logic                  start_pps_c;

  logic [PW_W-1:0]       pps_rem;

  assign in_tod_c      = tod_in_data;
  assign unused_frac_c = ^in_tod_c.frac;

  // Stage 1: capture qualified samples
  always_ff @(posedge clk_tod_clk or negedge rst_tod_n_reset_n) begin
    if (!rst_tod_n_reset_n) begin
      s1_valid <= 1'b0;
      s1_sec   <= '0;
      s1_ns    <= '0;
    end else begin
      s1_valid <= tod_in_valid;
      if (tod_in_valid) begin
        s1_sec <= in_tod_c.sec;
        s1_ns  <= in_tod_c.ns;
      end
    end
  end

  // Count consecutive cycles without a valid sample, saturating at the limit
  always_ff @(posedge clk_tod_clk or negedge rst_tod_n_reset_n) begin
    if (!rst_tod_n_reset_n) begin
      to_cnt <= '0;
    end else if (tod_in_valid) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_W'(VALID_TIMEOUT)) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Fires once, in the cycle the idle count reaches the limit
  assign timeout_c = !tod_in_valid && (to_cnt == TO_W'(VALID_TIMEOUT - 1));

  // Stage 2 checks against the last accepted seconds value
  assign ns_bad_c    = s1_valid && (s1_ns >= NS_PER_SEC);
  assign sec_same_c  = (s1_sec == seconds_out);
  assign sec_next_c  = (s1_sec == SEC_W'(seconds_out + SEC_W'(1)));
  assign mono_bad_c  = s1_valid && (state != UNLOCKED) && !(sec_same_c || sec_next_c);
  assign good_c      = s1_valid && !ns_bad_c && !mono_bad_c;
  assign start_pps_c = good_c && (state == LOCKED) && sec_next_c;
  assign cnt_inc_c   = (CNT_W+1)'(good_cnt) + (CNT_W+1)'(1);

  // Lock FSM: state register
  always_ff @(posedge clk_tod_clk or negedge rst_tod_n_reset_n) begin
    if (!rst_tod_n_reset_n) begin
      state    <= UNLOCKED;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
    end
  end

  // Lock FSM: next state and good-sample counter
  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    case (state)
      UNLOCKED: begin
        if (good_c) begin
          good_cnt_next = CNT_W'(1);
          state_next    = (LOCK_SAMPLES <= 1) ? LOCKED : ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (good_c) begin
          good_cnt_next = CNT_W'(cnt_inc_c);
          if (cnt_inc_c >= (CNT_W+1)'(LOCK_SAMPLES)) begin
            state_next = LOCKED;
          end
        end else if (s1_valid) begin
          state_next    = ns_bad_c ? UNLOCKED : ACQUIRE;
          good_cnt_next = ns_bad_c ? CNT_W'(0) : CNT_W'(1);
        end
      end
      LOCKED: begin
        if (s1_valid && !good_c) begin
          state_next    = ns_bad_c ? UNLOCKED : ACQUIRE;
          good_cnt_next = ns_bad_c ? CNT_W'(0) : CNT_W'(1);
        end
      end
      default: begin
        state_next    = UNLOCKED;
        good_cnt_next = '0;
      end
    endcase
    if (timeout_c) begin
      state_next    = UNLOCKED;
      good_cnt_next = '0;
    end
  end

  // Registered status outputs and last accepted seconds
  always_ff @(posedge clk_tod_clk or negedge rst_tod_n_reset_n) begin
    if (!rst_tod_n_reset_n) begin
      locked        <= 1'b0;
      err_ns_range  <= 1'b0;
      err_monotonic <= 1'b0;
      seconds_out   <= '0;
    end else begin
      locked        <= (state_next == LOCKED);
      err_ns_range  <= ns_bad_c;
      err_monotonic <= mono_bad_c;
      if (s1_valid && !ns_bad_c) begin
        seconds_out <= s1_sec;
      end
    end
  end

  // PPS pulse generator; a new rollover reloads the width (extends the pulse)
  always_ff @(posedge clk_tod_clk or negedge rst_tod_n_reset_n) begin
    if (!rst_tod_n_reset_n) begin
      pps_out <= 1'b0;
      pps_rem <= '0;
    end else if (start_pps_c) begin
      pps_out <= 1'b1;
      pps_rem <= PW_W'(PPS_WIDTH);
    end else if (pps_out) begin
      if (pps_rem <= PW_W'(1)) begin
        pps_out <= 1'b0;
        pps_rem <= '0;
      end else begin
        pps_rem <= pps_rem - PW_W'(1);
      end
    end
  end

`ifdef ORAN_TOD_PPS_ERR_CNT_EN
  logic [16:0] err_sum_c;

  assign err_sum_c = 17'(err_count) + 17'(ns_bad_c) + 17'(mono_bad_c);

  // Saturating error counter, both flags in one cycle count as two
  always_ff @(posedge clk_tod_clk or negedge rst_tod_n_reset_n) begin
    if (!rst_tod_n_reset_n) begin
      err_count <= '0;
    end else begin
      err_count <= err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
    end
  end
`else
  assign err_count = 16'd0;
`endif

endmodule
